// File: rtl/ex_muldiv_sequencer_if.sv
// ex_muldiv_sequencer_if: EX-stage M-extension request/response bundle.
// Slave side (sequencer) inputs: start, funct3, data1, data2, flush.
// Slave side outputs: stall, done, result.
interface ex_muldiv_sequencer_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  modport master (output start, funct3, data1, data2, flush, input stall, done, result);
  modport slave  (input start, funct3, data1, data2, flush, output stall, done, result);
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: multi-cycle RV32M multiply/divide controller beside the EX ALU.
// Ports: clk, reset (async, active-high), bus (slave modport: start/funct3/data1/data2/flush in,
// stall/done/result out). Optional macro DIV_EARLY_OUT_EN finishes |dividend| < |divisor| divides at once.
module ex_muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  ex_muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d, rem_q, rem_d, res_q, res_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d, sgn_q, sgn_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sa, sb, div0, ovf, early;
  logic [XLEN-1:0] ma, mb, q_fix, r_fix;
  logic [2*XLEN-1:0] xa, xb, prod;
  logic [XLEN:0]   t, diff;
  always_comb begin
    sa    = ~bus.funct3[0] & bus.data1[XLEN-1];
    sb    = ~bus.funct3[0] & bus.data2[XLEN-1];
    ma    = sa ? -bus.data1 : bus.data1;
    mb    = sb ? -bus.data2 : bus.data2;
    div0  = bus.data2 == '0;
    ovf   = ~bus.funct3[0] & (bus.data1 == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.data2);
`ifdef DIV_EARLY_OUT_EN
    early = ma < mb;
`else
    early = 1'b0;
`endif
    // MULHU zero-extends rs1; only MUL/MULH sign-extend rs2
    xa    = {{XLEN{~(&f3_q[1:0]) & opa_q[XLEN-1]}}, opa_q};
    xb    = {{XLEN{~f3_q[1] & opb_q[XLEN-1]}}, opb_q};
    prod  = xa * xb;
    // opa_q shifts out dividend bits while shifting in quotient bits
    t     = {rem_q, opa_q[XLEN-1]};
    diff  = t - {1'b0, opb_q};
    q_fix = neg_q ? -opa_q : opa_q;
    r_fix = sgn_q ? -rem_q : rem_q;
  end
  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    rem_d      = rem_q;
    res_d      = res_q;
    f3_d       = f3_q;
    neg_d      = neg_q;
    sgn_d      = sgn_q;
    cnt_d      = cnt_q;
    bus.stall  = 1'b0;
    bus.done   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.stall = bus.start & ~bus.flush;
        if (bus.start & ~bus.flush) begin
          f3_d = bus.funct3;
          if (!bus.funct3[2]) begin
            opa_d   = bus.data1;
            opb_d   = bus.data2;
            state_d = MUL;
          end else begin
            opa_d   = ma;
            opb_d   = mb;
            rem_d   = '0;
            cnt_d   = '0;
            neg_d   = sa ^ sb;
            sgn_d   = sa;
            state_d = (div0 | ovf | early) ? DONE : DIV;
            res_d   = div0  ? (bus.funct3[1] ? bus.data1 : '1) :
                      ovf   ? (bus.funct3[1] ? '0 : bus.data1) :
                      early ? (bus.funct3[1] ? bus.data1 : '0) : res_q;
          end
        end
      end
      MUL: begin
        bus.stall = 1'b1;
        res_d     = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        state_d   = DONE;
      end
      DIV: begin
        bus.stall = 1'b1;
        // one extra pass after the last quotient bit applies the sign fix-up
        if (cnt_q == CW'(XLEN)) begin
          res_d   = f3_q[1] ? r_fix : q_fix;
          state_d = DONE;
        end else begin
          rem_d = diff[XLEN] ? t[XLEN-1:0] : diff[XLEN-1:0];
          opa_d = {opa_q[XLEN-2:0], ~diff[XLEN]};
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
    endcase
    if (bus.flush) begin
      state_d  = IDLE;
      res_d    = res_q;
      bus.done = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.result = res_q;
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// tb_ex_muldiv_sequencer: directed self-checking bench for ex_muldiv_sequencer.
module tb_ex_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
`ifdef DIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 34;
`endif
  ex_muldiv_sequencer_if bus();
  ex_muldiv_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int k0, input int lat, input logic [31:0] exp);
    int k;
    bit got, sok;
    k = k0; got = 0; sok = 1;
    while (!got && k < 80) begin
      @(negedge clk);
      k++;
      if (bus.done) got = 1;
      else if (!bus.stall) sok = 0;
    end
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " result"}, bus.result, exp);
    check({tag, " stall_held"}, {31'd0, sok & ~bus.stall}, 32'd1);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f; bus.data1 = a; bus.data2 = b;
    #1 check("stall_at_start", {31'd0, bus.stall}, 32'd1);
    @(posedge clk);
    #1 bus.start = 1'b0; bus.data1 = 32'hDEAD_BEEF; bus.data2 = 32'h0BAD_F00D; bus.funct3 = 3'b000;
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [31:0] exp);
    issue(f, a, b);
    wait_done(tag, 0, lat, exp);
  endtask

  task automatic quiet(input string tag, input int n);
    bit ok;
    ok = 1;
    repeat (n) begin
      @(negedge clk);
      if (bus.done || bus.stall) ok = 0;
    end
    check({tag, " quiet"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.funct3 = 3'b000; bus.data1 = '0; bus.data2 = '0; bus.flush = 1'b0;
    #2;
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    run("MUL", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 2, 32'hFFFF_FFEB);
    run("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
    run("MULH", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'h0000_0000);
    run("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 2, 32'hFFFF_FFFF);
    run("DIV", 3'b100, 32'hFFFF_FFEC, 32'h0000_0003, 34, 32'hFFFF_FFFA);
    run("REM", 3'b110, 32'hFFFF_FFEC, 32'h0000_0003, 34, 32'hFFFF_FFFE);
    run("DIVU", 3'b101, 32'd100, 32'd7, 34, 32'd14);
    run("REMU", 3'b111, 32'd100, 32'd7, 34, 32'd2);
    run("DIV_by0", 3'b100, 32'h0000_0005, 32'h0, 1, 32'hFFFF_FFFF);
    run("DIV_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run("REM_by0", 3'b110, 32'h0000_1234, 32'h0, 1, 32'h0000_1234);
    run("REM_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);
    run("DIVU_small", 3'b101, 32'd3, 32'd10, EL, 32'd0);
    run("REMU_small", 3'b111, 32'd3, 32'd10, EL, 32'd3);
    run("REM_small_neg", 3'b110, 32'hFFFF_FFFD, 32'd10, EL, 32'hFFFF_FFFD);
    // flush together with start in IDLE: not accepted
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b000; bus.data1 = 32'd9; bus.data2 = 32'd9;
    #1 check("flush_start_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1 bus.start = 1'b0; bus.flush = 1'b0;
    quiet("flush_start", 4);
    check("flush_start_result", bus.result, 32'hFFFF_FFFD);
    // flush mid-divide
    issue(3'b101, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    #1 check("flush_stall_T5", {31'd0, bus.stall}, 32'd1);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    quiet("after_flush", 2);
    check("flush_result_held", bus.result, 32'hFFFF_FFFD);
    run("DIVU_after_flush", 3'b101, 32'd100, 32'd7, 34, 32'd14);
    // reset mid-divide
    issue(3'b100, 32'hFFFF_FFEC, 32'd3);
    repeat (4) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_stall", {31'd0, bus.stall}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    quiet("after_reset", 3);
    run("REMU_after_reset", 3'b111, 32'd100, 32'd7, 34, 32'd2);
    // start pulse during DIV is ignored
    issue(3'b101, 32'd100, 32'd7);
    @(negedge clk); @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.data1 = 32'd5; bus.data2 = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done("DIVU_ignore_start", 3, 34, 32'd14);
    quiet("no_second_done", 4);
    check("result_held", bus.result, 32'd14);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
